// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: multi-mode RGB888 test-pattern generator with a two-stage pipeline.
// Define PATTERN_BOX_EN to build the bouncing-box pattern (mode 4); otherwise mode 4 is black.
module hdmi_pattern_gen #(
  parameter int H_DISP      = 800,
  parameter int V_DISP      = 600,
  parameter int COORD_W     = 11,
  parameter int BAR_NUM     = 8,
  parameter int CHECK_SHIFT = 5,
  parameter int BOX_SIZE    = 64
) (
  input  logic               pixel_clk,
  input  logic               sys_rst,
  input  logic [COORD_W-1:0] pixel_xpos,
  input  logic [COORD_W-1:0] pixel_ypos,
  input  logic               data_req,
  input  logic [2:0]         mode_sel,
  input  logic [23:0]        solid_color,
  output logic [23:0]        pixel_data,
  output logic               pixel_valid,
  output logic [15:0]        frame_cnt
);
  localparam int BAR_W = H_DISP / BAR_NUM;
  localparam logic [23:0] PAL [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic              frame_start, frame_end, hit;
  logic [2:0]        bar_idx, bar1_q, mode_q;
  logic [7:0]        grey1_q;
  logic              chk1_q, req1_q, hit1_q, valid_q;
  logic [23:0]       color_q, data_q, data_d;
  logic [15:0]       frame_cnt_q;
  assign frame_start = data_req && pixel_xpos == '0 && pixel_ypos == '0;
  assign frame_end   = data_req && pixel_xpos == COORD_W'(H_DISP - 1) && pixel_ypos == COORD_W'(V_DISP - 1);
  // a 3-bit count of crossed boundaries is already the palette index mod 8
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < BAR_NUM; k++)
      if (int'(pixel_xpos) >= k * BAR_W) bar_idx = bar_idx + 3'd1;
  end
`ifdef PATTERN_BOX_EN
  logic [COORD_W-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic               neg_x_q, neg_x_d, neg_y_q, neg_y_d;
  // the position always steps in the (possibly just flipped) direction
  function automatic logic [COORD_W:0] bounce(input logic [COORD_W-1:0] p, input logic neg, input int lim);
    logic nd;
    nd = neg ^ (neg ? p == '0 : int'(p) + BOX_SIZE == lim);
    return {nd, nd ? p - COORD_W'(1) : p + COORD_W'(1)};
  endfunction
  always_comb begin
    {neg_x_d, box_x_d} = frame_end ? bounce(box_x_q, neg_x_q, H_DISP) : {neg_x_q, box_x_q};
    {neg_y_d, box_y_d} = frame_end ? bounce(box_y_q, neg_y_q, V_DISP) : {neg_y_q, box_y_q};
    hit = int'(pixel_xpos) >= int'(box_x_q) && int'(pixel_xpos) < int'(box_x_q) + BOX_SIZE &&
          int'(pixel_ypos) >= int'(box_y_q) && int'(pixel_ypos) < int'(box_y_q) + BOX_SIZE;
  end
  always_ff @(posedge pixel_clk or posedge sys_rst)
    if (sys_rst) {neg_x_q, box_x_q, neg_y_q, box_y_q} <= '0;
    else {neg_x_q, box_x_q, neg_y_q, box_y_q} <= {neg_x_d, box_x_d, neg_y_d, box_y_d};
`else
  assign hit = 1'b0;
`endif
  // hit is decided in stage 1 so the frame's last pixel still sees the old box position
  always_ff @(posedge pixel_clk or posedge sys_rst)
    if (sys_rst) begin
      {bar1_q, grey1_q, chk1_q, req1_q, hit1_q} <= '0;
      mode_q      <= '0;
      color_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      bar1_q  <= bar_idx;
      grey1_q <= pixel_xpos[7:0];
      chk1_q  <= pixel_xpos[CHECK_SHIFT] ^ pixel_ypos[CHECK_SHIFT];
      req1_q  <= data_req;
      hit1_q  <= hit;
      if (frame_start) begin
        mode_q  <= mode_sel;
        color_q <= solid_color;
      end
      if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  always_comb
    data_d = !req1_q         ? '0 :
             mode_q == 3'd0  ? PAL[bar1_q] :
             mode_q == 3'd1  ? (chk1_q ? 24'h000000 : 24'hFFFFFF) :
             mode_q == 3'd2  ? {grey1_q, grey1_q, grey1_q} :
             mode_q == 3'd3  ? color_q :
             mode_q == 3'd4 && hit1_q ? 24'hFF0000 : 24'h000000;
  always_ff @(posedge pixel_clk or posedge sys_rst)
    if (sys_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= req1_q;
    end
  assign pixel_data  = data_q;
  assign pixel_valid = valid_q;
  assign frame_cnt   = frame_cnt_q;
endmodule
